cci_mem_responder: RTL and testbench
====================================

CCI_MEM_RESPONDER -- requirements
Module: cci_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: line-address width; memory holds 2^ADDR_WIDTH lines.
REQ-002 SHALL have parameter LINE_WIDTH, default 512: bits per cache line.
REQ-003 SHALL have parameter MDATA_WIDTH, default 16: request tag width, echoed on responses.
REQ-004 SHALL have parameter RD_LATENCY, default 4 (legal 1..16): cycles from read accept to response-queue entry.
REQ-005 SHALL have parameter QUEUE_DEPTH, default 8 (power of 2, >= RD_LATENCY): maximum outstanding reads.
REQ-006 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-008 SHALL have ports c0_req_valid  in  1; c0_req_addr  in  ADDR_WIDTH; c0_req_mdata  in  MDATA_WIDTH: read request.
REQ-009 SHALL have ports c1_req_valid  in  1; c1_req_addr  in  ADDR_WIDTH; c1_req_mdata  in  MDATA_WIDTH; c1_req_data  in  LINE_WIDTH: write request.
REQ-010 SHALL have ports init_en  in  1; init_addr  in  ADDR_WIDTH; init_data  in  LINE_WIDTH: bench preload.
REQ-011 SHALL have port rsp_hold  in  1: while high, read responses are not popped.
REQ-012 SHALL have ports c0_rsp_valid  out  1; c0_rsp_data  out  LINE_WIDTH; c0_rsp_mdata  out  MDATA_WIDTH: read response.
REQ-013 SHALL have ports c1_rsp_valid  out  1; c1_rsp_mdata  out  MDATA_WIDTH: write acknowledge.
REQ-014 SHALL have ports c0_almost_full  out  1; c1_almost_full  out  1; overflow  out  1: flow-control and sticky error flags.

Function
REQ-015 SHALL write memory[c1_req_addr] = c1_req_data at the edge where c1_req_valid is high.
REQ-016 SHALL write memory[init_addr] = init_data when init_en is high; if c1_req_valid targets the same address in the same cycle, the c1 write SHALL win.
REQ-017 SHALL sample read data at accept; a same-cycle c1 write to the same address SHALL be forwarded (write-first).
REQ-018 SHALL carry {data, mdata} through an RD_LATENCY-stage pipeline, then push it into a response FIFO of QUEUE_DEPTH entries.
REQ-019 SHALL pop one FIFO entry per cycle when non-empty and rsp_hold is low, registering it onto c0_rsp_valid/data/mdata; minimum request-to-response latency is RD_LATENCY+1 cycles.
REQ-020 SHALL deliver read responses in request order.
REQ-021 SHALL keep an in-flight counter: +1 on accepted read, -1 on response pop, net 0 when both occur in one cycle.
REQ-022 SHALL assert c0_almost_full combinationally when in-flight >= QUEUE_DEPTH-2.
REQ-023 SHALL drop a read arriving with in-flight == QUEUE_DEPTH (no pipeline entry, counter unchanged) and set overflow, sticky until reset.
REQ-024 SHALL assert c1_rsp_valid exactly 1 cycle after an accepted write, with c1_rsp_mdata = c1_req_mdata; c1_almost_full SHALL be constant 0.
REQ-025 SHALL drive c0_rsp_data/mdata and c1_rsp_mdata to 0 in cycles where the matching valid is low.
REQ-026 SHALL accept a read and a write in the same cycle independently.

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear all valids, response data/mdata, the almost_full flags, overflow, the in-flight counter, pipeline valids, and FIFO pointers.
REQ-028 SHALL NOT clear memory contents on reset; preloaded data survives.
REQ-029 SHALL discard reads in flight at reset assertion; no response for them ever appears.
REQ-030 SHALL ignore requests while reset is high; accept resumes on the first edge after deassertion.

Verification
REQ-031 SHALL pass: preload addr 3 = 0x...CAFE, read addr 3 mdata 0x11 -> c0_rsp_valid exactly 5 cycles later, data 0x...CAFE, mdata 0x11.
REQ-032 SHALL pass: same-cycle write addr 5 = 0x77 (mdata 0x2) and read addr 5 -> read returns 0x77; c1_rsp_valid next cycle with mdata 0x2.
REQ-033 SHALL pass: rsp_hold high, 6 back-to-back reads -> c0_almost_full high from the 6th accept; release -> 6 responses in order, one per cycle.
REQ-034 SHALL pass: rsp_hold high, 9 reads -> 9th dropped, overflow=1, in-flight=8; release -> exactly 8 responses.
REQ-035 SHALL pass: reset pulse with 3 reads in flight -> no responses follow, overflow=0, preloaded memory still readable unchanged.
REQ-036 SHALL pass: init_en and c1 write both to addr 2 (0xAA vs 0xBB) -> subsequent read returns 0xBB.

Source files
------------

// File: rtl/cci_mem_responder.sv
// cci_mem_responder
//   Behavioural CCI-style memory endpoint used by block-level benches.
//   A small line-addressed memory serves reads (channel 0) through a
//   fixed-latency pipeline and an in-order response FIFO, and acknowledges
//   writes (channel 1) one cycle after they are taken.
//
// Ports
//   clk, reset                          clock, async active-high reset
//   c0_req_valid/addr/mdata             read request
//   c1_req_valid/addr/mdata/data        write request
//   init_en/addr/data                   bench preload port
//   rsp_hold                            stall read-response delivery
//   c0_rsp_valid/data/mdata             read response (zero when idle)
//   c1_rsp_valid/mdata                  write ack (zero when idle)
//   c0_almost_full, c1_almost_full      flow control
//   overflow                            sticky: a read was dropped
module cci_mem_responder #(
  parameter int ADDR_WIDTH  = 4,
  parameter int LINE_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16,
  parameter int RD_LATENCY  = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  input  logic                   c1_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  input  logic [LINE_WIDTH-1:0]  c1_req_data,
  input  logic                   init_en,
  input  logic [ADDR_WIDTH-1:0]  init_addr,
  input  logic [LINE_WIDTH-1:0]  init_data,
  input  logic                   rsp_hold,
  output logic                   c0_rsp_valid,
  output logic [LINE_WIDTH-1:0]  c0_rsp_data,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic                   c0_almost_full,
  output logic                   c1_almost_full,
  output logic                   overflow
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef struct packed {
    logic [LINE_WIDTH-1:0]  data;
    logic [MDATA_WIDTH-1:0] mdata;
  } rd_ent_t;

  logic [LINE_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [CW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY:1]   vld_pipe_q;
  rd_ent_t               ent_pipe_q [RD_LATENCY:1];
  rd_ent_t               fifo_q [2**PW];
  logic [PW:0]           wr_ptr_q, rd_ptr_q;

  logic                  c0_rsp_valid_q, c1_rsp_valid_q, overflow_q;
  logic [LINE_WIDTH-1:0] c0_rsp_data_q;
  logic [MDATA_WIDTH-1:0] c0_rsp_mdata_q, c1_rsp_mdata_q;

  logic    c1_acc, rd_full, rd_acc, rd_drop, push, pop;
  rd_ent_t rd_ent;

  // Requests seen while reset is high are ignored.
  assign c1_acc  = c1_req_valid & ~reset;
  assign rd_full = (inflight_q == CW'(QUEUE_DEPTH));
  assign rd_acc  = c0_req_valid & ~reset & ~rd_full;
  assign rd_drop = c0_req_valid & ~reset & rd_full;
  assign push    = vld_pipe_q[RD_LATENCY];
  assign pop     = (wr_ptr_q != rd_ptr_q) & ~rsp_hold;

  // Read data is captured at accept; a same-cycle write to the same line
  // is forwarded so the read observes the new value.
  always_comb begin
    rd_ent.mdata = c0_req_mdata;
    rd_ent.data  = mem[c0_req_addr];
    if (c1_acc && (c1_req_addr == c0_req_addr)) rd_ent.data = c1_req_data;
  end

  // Memory is not reset so preloaded contents survive. The c1 write is
  // issued last so it wins over init on an address collision.
  always_ff @(posedge clk) begin
    if (init_en) mem[init_addr] <= init_data;
    if (c1_acc)  mem[c1_req_addr] <= c1_req_data;
  end

  // Payload registers carry no reset; only the valid bits matter.
  always_ff @(posedge clk) begin
    ent_pipe_q[1] <= rd_ent;
    for (int i = 2; i <= RD_LATENCY; i++) ent_pipe_q[i] <= ent_pipe_q[i-1];
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= ent_pipe_q[RD_LATENCY];
  end

  // The in-flight count covers pipeline plus FIFO, so the FIFO can never
  // be pushed while full.
  always_comb begin
    inflight_d = inflight_q;
    case ({rd_acc, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= '0;
      overflow_q     <= 1'b0;
      c0_rsp_valid_q <= 1'b0;
      c0_rsp_data_q  <= '0;
      c0_rsp_mdata_q <= '0;
      c1_rsp_valid_q <= 1'b0;
      c1_rsp_mdata_q <= '0;
    end else begin
      vld_pipe_q[1] <= rd_acc;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      inflight_q     <= inflight_d;
      overflow_q     <= overflow_q | rd_drop;
      c0_rsp_valid_q <= pop;
      c0_rsp_data_q  <= pop ? fifo_q[rd_ptr_q[PW-1:0]].data  : '0;
      c0_rsp_mdata_q <= pop ? fifo_q[rd_ptr_q[PW-1:0]].mdata : '0;
      c1_rsp_valid_q <= c1_acc;
      c1_rsp_mdata_q <= c1_acc ? c1_req_mdata : '0;
    end
  end

  assign c0_rsp_valid   = c0_rsp_valid_q;
  assign c0_rsp_data    = c0_rsp_data_q;
  assign c0_rsp_mdata   = c0_rsp_mdata_q;
  assign c1_rsp_valid   = c1_rsp_valid_q;
  assign c1_rsp_mdata   = c1_rsp_mdata_q;
  assign c0_almost_full = (int'(inflight_q) >= QUEUE_DEPTH - 2);
  assign c1_almost_full = 1'b0;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_cci_mem_responder.sv
// Self-checking bench for cci_mem_responder. Expected read responses are
// queued when a read is driven and compared in order as responses appear.
module tb_cci_mem_responder;
  localparam int AW = 4, LW = 512, MW = 16, LAT = 4, QD = 8;

  logic          clk = 1'b0, reset;
  logic          c0_req_valid, c1_req_valid, init_en, rsp_hold;
  logic [AW-1:0] c0_req_addr, c1_req_addr, init_addr;
  logic [MW-1:0] c0_req_mdata, c1_req_mdata;
  logic [LW-1:0] c1_req_data, init_data;
  logic          c0_rsp_valid, c1_rsp_valid, c0_almost_full, c1_almost_full, overflow;
  logic [LW-1:0] c0_rsp_data;
  logic [MW-1:0] c0_rsp_mdata, c1_rsp_mdata;

  cci_mem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MDATA_WIDTH(MW),
                      .RD_LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .rsp_hold(rsp_hold),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data), .c0_rsp_mdata(c0_rsp_mdata),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .c0_almost_full(c0_almost_full), .c1_almost_full(c1_almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] d;
    logic [MW-1:0] m;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [LW-1:0] model_mem [2**AW];
  int            checks = 0, failures = 0, rsp_cnt = 0;
  logic [LW-1:0] cafe = {{31{16'h5EED}}, 16'hCAFE};

  // Response scoreboard: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (c0_rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp got mdata=%h, no response outstanding", c0_rsp_mdata);
      end else begin
        mon_e = sb.pop_front();
        if (c0_rsp_data !== mon_e.d || c0_rsp_mdata !== mon_e.m) begin
          failures++;
          $display("FAIL rsp_data got mdata=%h data=%h exp mdata=%h data=%h",
                   c0_rsp_mdata, c0_rsp_data, mon_e.m, mon_e.d);
        end
      end
    end else if (c0_rsp_data !== '0 || c0_rsp_mdata !== '0) begin
      checks++;
      failures++;
      $display("FAIL rsp_idle_zero got mdata=%h data=%h exp 0", c0_rsp_mdata, c0_rsp_data);
    end
    if (!c1_rsp_valid && c1_rsp_mdata !== '0) begin
      checks++;
      failures++;
      $display("FAIL c1_idle_zero got %h exp 0", c1_rsp_mdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
    init_en = 1'b1; init_addr = a; init_data = d;
    cyc();
    init_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    c1_req_valid = 1'b1; c1_req_addr = 4'd1; c1_req_mdata = 16'h7; c1_req_data = '1;
    repeat (3) cyc();
    checks += 6;
    if (c0_rsp_valid !== 1'b0)   begin failures++; $display("FAIL rst_c0_valid got %b exp 0", c0_rsp_valid); end
    if (c1_rsp_valid !== 1'b0)   begin failures++; $display("FAIL rst_c1_valid got %b exp 0", c1_rsp_valid); end
    if (c0_rsp_data !== '0)      begin failures++; $display("FAIL rst_c0_data got %h exp 0", c0_rsp_data); end
    if (c0_almost_full !== 1'b0) begin failures++; $display("FAIL rst_c0_af got %b exp 0", c0_almost_full); end
    if (c1_almost_full !== 1'b0) begin failures++; $display("FAIL rst_c1_af got %b exp 0", c1_almost_full); end
    if (overflow !== 1'b0)       begin failures++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    c1_req_valid = 1'b0;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_read_latency();
    int lat;
    preload(4'd3, cafe);
    sb.push_back('{model_mem[3], 16'h11});
    c0_req_valid = 1'b1; c0_req_addr = 4'd3; c0_req_mdata = 16'h11;
    cyc();
    c0_req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      cyc();
      if (c0_rsp_valid) lat = k;
    end
    checks++;
    if (lat != LAT + 1) begin failures++; $display("FAIL read_latency got %0d exp %0d", lat, LAT + 1); end
    cyc();
  endtask

  task automatic test_write_fwd();
    c1_req_valid = 1'b1; c1_req_addr = 4'd5; c1_req_mdata = 16'h2; c1_req_data = LW'(8'h77);
    c0_req_valid = 1'b1; c0_req_addr = 4'd5; c0_req_mdata = 16'h21;
    sb.push_back('{LW'(8'h77), 16'h21});
    model_mem[5] = LW'(8'h77);
    cyc();
    c1_req_valid = 1'b0; c0_req_valid = 1'b0;
    checks += 2;
    if (c1_rsp_valid !== 1'b1)  begin failures++; $display("FAIL wr_ack_valid got %b exp 1", c1_rsp_valid); end
    if (c1_rsp_mdata !== 16'h2) begin failures++; $display("FAIL wr_ack_mdata got %h exp 2", c1_rsp_mdata); end
    cyc();
    checks++;
    if (c1_rsp_valid !== 1'b0)  begin failures++; $display("FAIL wr_ack_once got %b exp 0", c1_rsp_valid); end
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL fwd_drain got %0d pending exp 0", sb.size()); end
  endtask

  task automatic test_init_vs_write();
    init_en = 1'b1; init_addr = 4'd2; init_data = LW'(8'hAA);
    c1_req_valid = 1'b1; c1_req_addr = 4'd2; c1_req_mdata = 16'h3; c1_req_data = LW'(8'hBB);
    cyc();
    init_en = 1'b0; c1_req_valid = 1'b0;
    model_mem[2] = LW'(8'hBB);
    c0_req_valid = 1'b1; c0_req_addr = 4'd2; c0_req_mdata = 16'h36;
    sb.push_back('{LW'(8'hBB), 16'h36});
    cyc();
    c0_req_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL init_drain got %0d pending exp 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic          wv, prev_wv;
    logic [MW-1:0] prev_wm;
    logic [LW-1:0] wd, rd_exp;
    prev_wv = 1'b0; prev_wm = '0;
    for (int i = 0; i < 40; i++) begin
      wv = 1'($urandom_range(0, 1));
      wd = {16{$urandom()}};
      c1_req_valid = wv; c1_req_addr = 4'($urandom_range(0, 15));
      c1_req_mdata = 16'h100 + 16'(i); c1_req_data = wd;
      c0_req_valid = 1'($urandom_range(0, 1));
      c0_req_addr = 4'($urandom_range(0, 15)); c0_req_mdata = 16'h200 + 16'(i);
      rd_exp = (wv && c1_req_addr == c0_req_addr) ? wd : model_mem[c0_req_addr];
      if (c0_req_valid) sb.push_back('{rd_exp, c0_req_mdata});
      if (wv) model_mem[c1_req_addr] = wd;
      prev_wv = wv; prev_wm = c1_req_mdata;
      cyc();
      checks++;
      if (c1_rsp_valid !== prev_wv || (prev_wv && c1_rsp_mdata !== prev_wm)) begin
        failures++;
        $display("FAIL b2b_ack got v=%b m=%h exp v=%b m=%h", c1_rsp_valid, c1_rsp_mdata, prev_wv, prev_wm);
      end
    end
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    for (int k = 0; k < 30 && sb.size() != 0; k++) cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain got %0d pending exp 0", sb.size()); end
  endtask

  task automatic test_almost_full();
    int n0, first, last, n;
    rsp_hold = 1'b1;
    c0_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c0_req_addr = 4'(i); c0_req_mdata = 16'h40 + 16'(i);
      sb.push_back('{model_mem[i], c0_req_mdata});
      cyc();
      checks++;
      if (c0_almost_full !== (i >= 5)) begin
        failures++; $display("FAIL almost_full accept=%0d got %b exp %b", i + 1, c0_almost_full, i >= 5);
      end
    end
    c0_req_valid = 1'b0;
    n0 = rsp_cnt;
    repeat (8) cyc();
    checks++;
    if (rsp_cnt != n0) begin failures++; $display("FAIL hold_blocks got %0d rsps exp 0", rsp_cnt - n0); end
    rsp_hold = 1'b0;
    first = -1; last = -1; n = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (c0_rsp_valid) begin
        if (first < 0) first = k;
        last = k; n++;
      end
    end
    checks += 3;
    if (n != 6) begin failures++; $display("FAIL af_rsp_count got %0d exp 6", n); end
    if (last - first != 5) begin failures++; $display("FAIL af_rsp_burst got span %0d exp 5", last - first); end
    if (c0_almost_full !== 1'b0) begin failures++; $display("FAIL af_clear got %b exp 0", c0_almost_full); end
  endtask

  task automatic test_overflow();
    int n0;
    rsp_hold = 1'b1;
    c0_req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c0_req_addr = 4'(i); c0_req_mdata = 16'h80 + 16'(i);
      if (i < 8) sb.push_back('{model_mem[i], c0_req_mdata});
      cyc();
      if (i == 7) begin
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
    end
    c0_req_valid = 1'b0;
    checks += 3;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", overflow); end
    if (dut.inflight_q !== 4'd8) begin failures++; $display("FAIL ovf_inflight got %0d exp 8", dut.inflight_q); end
    if (c0_almost_full !== 1'b1) begin failures++; $display("FAIL ovf_af got %b exp 1", c0_almost_full); end
    n0 = rsp_cnt;
    rsp_hold = 1'b0;
    repeat (20) cyc();
    checks += 3;
    if (rsp_cnt - n0 != 8) begin failures++; $display("FAIL ovf_rsp_count got %0d exp 8", rsp_cnt - n0); end
    if (sb.size() != 0) begin failures++; $display("FAIL ovf_drain got %0d pending exp 0", sb.size()); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_reset_flight();
    int n0;
    n0 = rsp_cnt;
    c0_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c0_req_addr = 4'(3 + i); c0_req_mdata = 16'hE0 + 16'(i);
      cyc();
    end
    #1 reset = 1'b1;
    #1;
    checks += 2;
    if (overflow !== 1'b0) begin failures++; $display("FAIL rf_ovf_async got %b exp 0", overflow); end
    if (c0_almost_full !== 1'b0) begin failures++; $display("FAIL rf_af got %b exp 0", c0_almost_full); end
    repeat (2) cyc();
    reset = 1'b0; c0_req_valid = 1'b0;
    repeat (15) cyc();
    checks += 2;
    if (rsp_cnt != n0) begin failures++; $display("FAIL rf_no_rsp got %0d rsps exp 0", rsp_cnt - n0); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL rf_ovf got %b exp 0", overflow); end
    c0_req_valid = 1'b1; c0_req_addr = 4'd3; c0_req_mdata = 16'h99;
    sb.push_back('{model_mem[3], 16'h99});
    cyc();
    c0_req_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rf_mem_kept got %0d pending exp 0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_mdata = '0; c1_req_data = '0;
    init_en = 1'b0; init_addr = '0; init_data = '0; rsp_hold = 1'b0;
    test_reset();
    for (int i = 0; i < 16; i++) preload(4'(i), {16{(32'(i) * 32'h01010101) ^ 32'h5A5A0000}});
    test_read_latency();
    test_write_fwd();
    test_init_vs_write();
    test_back_to_back();
    test_almost_full();
    test_overflow();
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
